// File: rtl/dm_hart_ctrl.sv
`default_nettype none
//============================================================================
// Module   : dm_hart_ctrl
// Desc     : Debug-module run control and abstract register-access sequencer
//            for a single hart. Optional macro DM_HALT_ON_RESET_EN makes the
//            hart leave reset with a halt request pending.
// Revision : 1.0 - initial release
//============================================================================
`ifndef CMD_REGNO_SIZE
`define CMD_REGNO_SIZE 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module dm_hart_ctrl #(
  parameter int CMD_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_rstn,
  input  logic                       haltreq,
  input  logic                       resumereq_w1,
  input  logic                       cmd_req,
  input  logic                       cmd_wr1_rd0,
  input  logic [`CMD_REGNO_SIZE-1:0] cmd_regno,
  input  logic [`DATA_WIDTH-1:0]     cmd_wdata,
  input  logic                       cmderr_clr,
  input  logic                       core_halted,
  input  logic                       core_read_data_valid,
  input  logic [`DATA_WIDTH-1:0]     core_read_data,
  output logic                       core_haltreq,
  output logic                       core_resumereq,
  output logic                       core_reg_access,
  output logic                       core_wr1_rd0,
  output logic [`CMD_REGNO_SIZE-1:0] core_regno,
  output logic [`DATA_WIDTH-1:0]     core_wdata,
  output logic                       cmd_busy,
  output logic                       cmd_done,
  output logic [`DATA_WIDTH-1:0]     cmd_rdata,
  output logic [2:0]                 cmderr,
  output logic                       allhalted,
  output logic                       allrunning,
  output logic                       allresumeack
);

  typedef enum logic [2:0] {
    ST_RUNNING  = 3'd0,
    ST_HALTING  = 3'd1,
    ST_HALTED   = 3'd2,
    ST_CMD      = 3'd3,
    ST_RESUMING = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(CMD_TIMEOUT);
  localparam logic [2:0]       c_err_busy   = 3'd1;
  localparam logic [2:0]       c_err_except = 3'd3;
  localparam logic [2:0]       c_err_halt   = 3'd4;
`ifdef DM_HALT_ON_RESET_EN
  localparam state_t c_rst_state      = ST_HALTING;
  localparam logic   c_rst_haltreq    = 1'b1;
  localparam logic   c_rst_allrunning = 1'b0;
`else
  localparam state_t c_rst_state      = ST_RUNNING;
  localparam logic   c_rst_haltreq    = 1'b0;
  localparam logic   c_rst_allrunning = 1'b1;
`endif

  state_t                     r_state, w_state;
  logic                       r_haltreq, w_haltreq;
  logic                       r_resumereq, w_resumereq;
  logic                       r_access, w_access;
  logic                       r_wr, w_wr;
  logic [`CMD_REGNO_SIZE-1:0] r_regno, w_regno;
  logic [`DATA_WIDTH-1:0]     r_wdata, w_wdata;
  logic                       r_busy, w_busy;
  logic                       r_done, w_done;
  logic [`DATA_WIDTH-1:0]     r_rdata, w_rdata;
  logic [2:0]                 r_cmderr, w_cmderr, w_err_new;
  logic                       r_allhalted, w_allhalted;
  logic                       r_allrunning, w_allrunning;
  logic                       r_ack, w_ack;
  logic [CNT_W-1:0]           r_cnt, w_cnt;

  always_comb begin
    w_state      = r_state;
    w_haltreq    = r_haltreq;
    w_resumereq  = r_resumereq;
    w_access     = r_access;
    w_wr         = r_wr;
    w_regno      = r_regno;
    w_wdata      = r_wdata;
    w_busy       = r_busy;
    w_done       = 1'b0;
    w_rdata      = r_rdata;
    w_err_new    = 3'd0;
    w_allhalted  = r_allhalted;
    w_allrunning = r_allrunning;
    w_ack        = r_ack;
    w_cnt        = r_cnt;

    case (r_state)
      ST_RUNNING: begin
        if (core_halted) begin
          w_state      = ST_HALTED;
          w_allhalted  = 1'b1;
          w_allrunning = 1'b0;
        end else if (haltreq) begin
          w_state   = ST_HALTING;
          w_haltreq = 1'b1;
        end
      end
      ST_HALTING: begin
        if (core_halted) begin
          w_state      = ST_HALTED;
          w_haltreq    = 1'b0;
          w_allhalted  = 1'b1;
          w_allrunning = 1'b0;
        end else if (!haltreq) begin
          w_state      = ST_RUNNING;
          w_haltreq    = 1'b0;
          w_allhalted  = 1'b0;
          w_allrunning = 1'b1;
        end
      end
      ST_HALTED: begin
        if (cmd_req) begin
          w_state  = ST_CMD;
          w_wr     = cmd_wr1_rd0;
          w_regno  = cmd_regno;
          w_wdata  = cmd_wdata;
          w_access = 1'b1;
          w_busy   = 1'b1;
          w_cnt    = '0;
        end else if (resumereq_w1 && !haltreq) begin
          w_state     = ST_RESUMING;
          w_resumereq = 1'b1;
          w_ack       = 1'b0;
        end
      end
      ST_CMD: begin
        w_cnt = r_cnt + 1'b1;
        if (cmd_req) w_err_new = c_err_busy;
        // A completion arriving on the timeout cycle still counts as success.
        if (core_read_data_valid) begin
          if (!r_wr) w_rdata = core_read_data;
          w_done   = 1'b1;
          w_busy   = 1'b0;
          w_access = 1'b0;
          w_state  = ST_HALTED;
        end else if (w_cnt == c_timeout) begin
          w_err_new = c_err_except;
          w_done    = 1'b1;
          w_busy    = 1'b0;
          w_access  = 1'b0;
          w_state   = ST_HALTED;
        end
      end
      ST_RESUMING: begin
        if (!core_halted) begin
          w_state      = ST_RUNNING;
          w_resumereq  = 1'b0;
          w_ack        = 1'b1;
          w_allrunning = 1'b1;
          w_allhalted  = 1'b0;
        end
      end
      default: w_state = ST_RUNNING;
    endcase

    if (cmd_req && (r_state != ST_HALTED) && (r_state != ST_CMD)) begin
      w_err_new = c_err_halt;
      w_done    = 1'b1;
    end

    if (cmderr_clr)            w_cmderr = 3'd0;
    else if (r_cmderr == 3'd0) w_cmderr = w_err_new;
    else                       w_cmderr = r_cmderr;
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_state      <= c_rst_state;
      r_haltreq    <= c_rst_haltreq;
      r_resumereq  <= 1'b0;
      r_access     <= 1'b0;
      r_wr         <= 1'b0;
      r_regno      <= '0;
      r_wdata      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rdata      <= '0;
      r_cmderr     <= 3'd0;
      r_allhalted  <= 1'b0;
      r_allrunning <= c_rst_allrunning;
      r_ack        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state;
      r_haltreq    <= w_haltreq;
      r_resumereq  <= w_resumereq;
      r_access     <= w_access;
      r_wr         <= w_wr;
      r_regno      <= w_regno;
      r_wdata      <= w_wdata;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_rdata      <= w_rdata;
      r_cmderr     <= w_cmderr;
      r_allhalted  <= w_allhalted;
      r_allrunning <= w_allrunning;
      r_ack        <= w_ack;
      r_cnt        <= w_cnt;
    end
  end

  assign core_haltreq    = r_haltreq;
  assign core_resumereq  = r_resumereq;
  assign core_reg_access = r_access;
  assign core_wr1_rd0    = r_wr;
  assign core_regno      = r_regno;
  assign core_wdata      = r_wdata;
  assign cmd_busy        = r_busy;
  assign cmd_done        = r_done;
  assign cmd_rdata       = r_rdata;
  assign cmderr          = r_cmderr;
  assign allhalted       = r_allhalted;
  assign allrunning      = r_allrunning;
  assign allresumeack    = r_ack;

endmodule

`default_nettype wire

// File: tb/tb_dm_hart_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_dm_hart_ctrl
// Desc     : Self-checking bench for dm_hart_ctrl: directed run-control and
//            abstract-command scenarios checked against a hart-level model.
// Revision : 1.0 - initial release
//============================================================================
`ifndef CMD_REGNO_SIZE
`define CMD_REGNO_SIZE 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_dm_hart_ctrl;

  localparam int TMO = 16;
  localparam int RW  = `CMD_REGNO_SIZE;
  localparam int DW  = `DATA_WIDTH;

  logic          sys_clk = 1'b0;
  logic          sys_rstn = 1'b0;
  logic          haltreq = 1'b0, resumereq_w1 = 1'b0, cmd_req = 1'b0;
  logic          cmd_wr1_rd0 = 1'b0, cmderr_clr = 1'b0;
  logic [RW-1:0] cmd_regno = '0;
  logic [DW-1:0] cmd_wdata = '0, core_read_data = '0;
  logic          core_halted = 1'b0, core_read_data_valid = 1'b0;
  logic          core_haltreq, core_resumereq, core_reg_access, core_wr1_rd0;
  logic [RW-1:0] core_regno;
  logic [DW-1:0] core_wdata, cmd_rdata;
  logic          cmd_busy, cmd_done, allhalted, allrunning, allresumeack;
  logic [2:0]    cmderr;

  always #5 sys_clk = ~sys_clk;

  dm_hart_ctrl #(.CMD_TIMEOUT(TMO), .CNT_W(8)) dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn), .haltreq(haltreq),
    .resumereq_w1(resumereq_w1), .cmd_req(cmd_req), .cmd_wr1_rd0(cmd_wr1_rd0),
    .cmd_regno(cmd_regno), .cmd_wdata(cmd_wdata), .cmderr_clr(cmderr_clr),
    .core_halted(core_halted), .core_read_data_valid(core_read_data_valid),
    .core_read_data(core_read_data), .core_haltreq(core_haltreq),
    .core_resumereq(core_resumereq), .core_reg_access(core_reg_access),
    .core_wr1_rd0(core_wr1_rd0), .core_regno(core_regno), .core_wdata(core_wdata),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_rdata(cmd_rdata),
    .cmderr(cmderr), .allhalted(allhalted), .allrunning(allrunning),
    .allresumeack(allresumeack)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hart-level view: a command is a sub-activity of being halted.
  localparam int M_RUN = 0, M_HALT_PEND = 1, M_HALTED = 2, M_RESUME_PEND = 3;
  int            m_hart;
  bit            m_cmd, m_allhalt, m_allrun, m_ack, m_done;
  int            m_age;
  logic          m_wr;
  logic [RW-1:0] m_regno;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [2:0]    m_err;

  task automatic model_reset();
`ifdef DM_HALT_ON_RESET_EN
    m_hart = M_HALT_PEND; m_allrun = 1'b0;
`else
    m_hart = M_RUN;       m_allrun = 1'b1;
`endif
    m_cmd = 0; m_allhalt = 0; m_ack = 0; m_done = 0; m_age = 0;
    m_wr = 0; m_regno = '0; m_wdata = '0; m_rdata = '0; m_err = 3'd0;
  endtask

  task automatic model_step();
    int  code = 0;
    bit  halted_before = (m_hart == M_HALTED);
    m_done = 0;
    if (m_cmd) begin
      m_age++;
      if (cmd_req) code = 1;
      if (core_read_data_valid) begin
        if (!m_wr) m_rdata = core_read_data;
        m_done = 1; m_cmd = 0;
      end else if (m_age == TMO) begin
        code = 3; m_done = 1; m_cmd = 0;
      end
    end else begin
      case (m_hart)
        M_RUN, M_HALT_PEND: begin
          if (core_halted) begin
            m_hart = M_HALTED; m_allhalt = 1; m_allrun = 0;
          end else if (m_hart == M_RUN && haltreq) begin
            m_hart = M_HALT_PEND;
          end else if (m_hart == M_HALT_PEND && !haltreq) begin
            m_hart = M_RUN; m_allhalt = 0; m_allrun = 1;
          end
        end
        M_HALTED: begin
          if (cmd_req) begin
            m_cmd = 1; m_age = 0;
            m_wr = cmd_wr1_rd0; m_regno = cmd_regno; m_wdata = cmd_wdata;
          end else if (resumereq_w1 && !haltreq) begin
            m_hart = M_RESUME_PEND; m_ack = 0;
          end
        end
        default: begin
          if (!core_halted) begin
            m_hart = M_RUN; m_ack = 1; m_allrun = 1; m_allhalt = 0;
          end
        end
      endcase
    end
    if (cmd_req && !halted_before) begin
      code = 4; m_done = 1;
    end
    if (cmderr_clr)                     m_err = 3'd0;
    else if (m_err == 3'd0 && code != 0) m_err = 3'(code);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sys_clk or negedge sys_rstn);
      if (!sys_rstn) model_reset();
      else           model_step();
    end
  end

  int acc_total = 0, hr_total = 0, rr_total = 0, done_total = 0;

  initial forever begin
    @(negedge sys_clk);
    check("core_haltreq",    core_haltreq,    m_hart == M_HALT_PEND);
    check("core_resumereq",  core_resumereq,  m_hart == M_RESUME_PEND);
    check("core_reg_access", core_reg_access, m_cmd);
    check("cmd_busy",        cmd_busy,        m_cmd);
    check("cmd_done",        cmd_done,        m_done);
    check("core_wr1_rd0",    core_wr1_rd0,    m_wr);
    check("core_regno",      core_regno,      m_regno);
    check("core_wdata",      core_wdata,      m_wdata);
    check("cmd_rdata",       cmd_rdata,       m_rdata);
    check("cmderr",          cmderr,          m_err);
    check("allhalted",       allhalted,       m_allhalt);
    check("allrunning",      allrunning,      m_allrun);
    check("allresumeack",    allresumeack,    m_ack);
    acc_total  += int'(core_reg_access);
    hr_total   += int'(core_haltreq);
    rr_total   += int'(core_resumereq);
    done_total += int'(cmd_done);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [RW-1:0] rg, input logic [DW-1:0] wd);
    cmd_wr1_rd0 = wr; cmd_regno = rg; cmd_wdata = wd; cmd_req = 1'b1;
    tick(1);
    cmd_req = 1'b0;
  endtask

  task automatic clear_err();
    cmderr_clr = 1'b1;
    tick(1);
    cmderr_clr = 1'b0;
    check("cmderr_cleared", cmderr, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, h0, r0;
    tick(3);
`ifdef DM_HALT_ON_RESET_EN
    check("rst_core_haltreq", core_haltreq, 1'b1);
    check("rst_allrunning",   allrunning,   1'b0);
`else
    check("rst_core_haltreq", core_haltreq, 1'b0);
    check("rst_allrunning",   allrunning,   1'b1);
`endif
    check("rst_cmderr", cmderr, 3'd0);
    sys_rstn = 1'b1;
    tick(1);

    // halt request, core acknowledges three cycles later
    h0 = hr_total; haltreq = 1'b1;
    tick(3);
    core_halted = 1'b1;
    tick(3);
    haltreq = 1'b0;
    check("halt_req_cycles", hr_total - h0, 3);
    check("halt_allhalted", allhalted, 1'b1);
    check("halt_allrunning", allrunning, 1'b0);

    // read command answered after four cycles
    a0 = acc_total; d0 = done_total;
    issue(1'b0, RW'('h1002), '0);
    tick(3);
    core_read_data_valid = 1'b1; core_read_data = DW'(32'hDEADBEEF);
    tick(1);
    core_read_data_valid = 1'b0;
    tick(2);
    check("rd_access_cycles", acc_total - a0, 4);
    check("rd_done_pulses", done_total - d0, 1);
    check("rd_rdata", cmd_rdata, DW'(32'hDEADBEEF));
    check("rd_regno", core_regno, RW'('h1002));
    check("rd_cmderr", cmderr, 3'd0);

    // write command, core never answers
    a0 = acc_total; d0 = done_total;
    issue(1'b1, RW'('h300), DW'(32'h12345678));
    tick(20);
    check("to_access_cycles", acc_total - a0, TMO);
    check("to_done_pulses", done_total - d0, 1);
    check("to_cmderr", cmderr, 3'd3);
    check("to_wdata", core_wdata, DW'(32'h12345678));
    check("to_rdata_kept", cmd_rdata, DW'(32'hDEADBEEF));
    clear_err();

    // second command while busy
    d0 = done_total;
    issue(1'b0, RW'('h1001), '0);
    tick(1);
    cmd_regno = RW'('h2222); cmd_req = 1'b1;
    tick(1);
    cmd_req = 1'b0;
    tick(1);
    core_read_data_valid = 1'b1; core_read_data = DW'(32'hCAFEF00D);
    tick(1);
    core_read_data_valid = 1'b0;
    tick(1);
    check("busy_cmderr", cmderr, 3'd1);
    check("busy_regno", core_regno, RW'('h1001));
    check("busy_rdata", cmd_rdata, DW'(32'hCAFEF00D));
    check("busy_done_pulses", done_total - d0, 1);
    clear_err();

    // clear coincident with a new error: the error is lost
    issue(1'b0, RW'('h5), '0);
    cmd_req = 1'b1; cmderr_clr = 1'b1;
    tick(1);
    cmd_req = 1'b0; cmderr_clr = 1'b0;
    check("clr_wins_cmderr", cmderr, 3'd0);
    core_read_data_valid = 1'b1; core_read_data = DW'(32'h55);
    tick(1);
    core_read_data_valid = 1'b0;
    tick(1);
    check("clr_wins_rdata", cmd_rdata, DW'(32'h55));

    // resume while haltreq held: ignored
    r0 = rr_total; haltreq = 1'b1; resumereq_w1 = 1'b1;
    tick(1);
    resumereq_w1 = 1'b0;
    tick(2);
    haltreq = 1'b0;
    check("res_ign_cycles", rr_total - r0, 0);
    check("res_ign_allhalted", allhalted, 1'b1);

    // resume, core leaves debug mode after two cycles
    r0 = rr_total; resumereq_w1 = 1'b1;
    tick(1);
    resumereq_w1 = 1'b0;
    tick(1);
    core_halted = 1'b0;
    tick(3);
    check("res_cycles", rr_total - r0, 2);
    check("res_ack", allresumeack, 1'b1);
    check("res_allrunning", allrunning, 1'b1);
    check("res_allhalted", allhalted, 1'b0);

    // command while running
    a0 = acc_total; d0 = done_total;
    issue(1'b0, RW'('h1000), '0);
    tick(2);
    check("run_cmd_cmderr", cmderr, 3'd4);
    check("run_cmd_access", acc_total - a0, 0);
    check("run_cmd_done", done_total - d0, 1);
    clear_err();

    // spontaneous halt beats a coincident haltreq
    h0 = hr_total; haltreq = 1'b1; core_halted = 1'b1;
    tick(2);
    haltreq = 1'b0;
    check("spont_haltreq", hr_total - h0, 0);
    check("spont_allhalted", allhalted, 1'b1);
    tick(1);

    // reset in the middle of a command
    d0 = done_total;
    issue(1'b1, RW'('h7), DW'(32'h1));
    tick(1);
    sys_rstn = 1'b0;
    #1;
    check("mid_rst_access", core_reg_access, 1'b0);
    check("mid_rst_busy", cmd_busy, 1'b0);
    tick(2);
    sys_rstn = 1'b1;
    tick(3);
    check("mid_rst_done", done_total - d0, 0);
    check("mid_rst_rehalted", allhalted, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dm_hart_ctrl.md
Name: dm_hart_ctrl

Overview:
- Run-control and command sequencer between the debug module register block and the single-hart core.
- Drives halt and resume requests to the core and tracks hart state.
- Gates abstract register-access commands so they reach the core only while it is halted, and returns completion status, cmderr and read data to the DM register block.
- Instantiated inside the debug module, between the register block / abstract-command decoder and the core debug interface.

Parameters:
- CMD_TIMEOUT, 255: cycles to wait for core_read_data_valid before aborting a command; 1..255.
- CNT_W, 8: width of the timeout counter; must hold CMD_TIMEOUT.

Ports:
- sys_clk  in  1  system clock
- sys_rstn  in  1  asynchronous active-low reset
- haltreq  in  1  dmcontrol.haltreq level
- resumereq_w1  in  1  one-cycle resume request pulse
- cmd_req  in  1  one-cycle pulse: decoded register-access command valid
- cmd_wr1_rd0  in  1  command direction
- cmd_regno  in  `CMD_REGNO_SIZE  command register number
- cmd_wdata  in  `DATA_WIDTH  command write data (data0)
- cmderr_clr  in  1  one-cycle W1C of abstractcs.cmderr
- core_halted  in  1  core in debug mode, level
- core_read_data_valid  in  1  core access completion, used for reads and writes
- core_read_data  in  `DATA_WIDTH  core read data
- core_haltreq  out  1  halt request to core, level
- core_resumereq  out  1  resume request to core, level
- core_reg_access  out  1  register access strobe, level
- core_wr1_rd0  out  1  latched direction
- core_regno  out  `CMD_REGNO_SIZE  latched regno
- core_wdata  out  `DATA_WIDTH  latched write data
- cmd_busy  out  1  abstractcs.busy
- cmd_done  out  1  one-cycle completion pulse
- cmd_rdata  out  `DATA_WIDTH  captured read data
- cmderr  out  3  abstractcs.cmderr
- allhalted  out  1  dmstatus.allhalted
- allrunning  out  1  dmstatus.allrunning
- allresumeack  out  1  dmstatus.allresumeack

Behaviour:
- Clocking/reset: one clock, sys_clk. Reset is asynchronous, active-low on sys_rstn.
- Reset state: all outputs 0 except allrunning=1; FSM in RUNNING; counter 0.
- FSM states: RUNNING, HALTING, HALTED, CMD, RESUMING. All outputs registered.
- RUNNING:
  - haltreq=1 -> HALTING, core_haltreq=1 from the next cycle.
  - core_halted=1 (spontaneous entry, e.g. ebreak) -> HALTED directly; core_halted has priority over haltreq.
- HALTING:
  - core_halted=1 -> HALTED, core_haltreq=0.
  - haltreq drops before core_halted -> RUNNING, core_haltreq=0.
- HALTED:
  - allhalted=1, allrunning=0.
  - resumereq_w1 with haltreq=0 -> RESUMING, core_resumereq=1, allresumeack=0.
  - resumereq_w1 with haltreq=1 is ignored.
  - cmd_req -> CMD: latch wr/regno/wdata, core_reg_access=1, cmd_busy=1, counter cleared.
  - cmd_req and resumereq_w1 in the same cycle: command wins, resume dropped.
- CMD:
  - core_reg_access held until core_read_data_valid.
  - On core_read_data_valid: cmd_rdata captured if read, unchanged if write; cmd_done pulses; busy=0; -> HALTED.
  - Counter increments each cycle. On reaching CMD_TIMEOUT without valid: cmderr=3 (if 0), cmd_done pulse, access dropped, -> HALTED.
  - resumereq_w1 ignored.
  - cmd_req -> cmderr=1 (if 0); the active command continues.
- RESUMING:
  - core_halted=0 -> RUNNING: core_resumereq=0, allresumeack=1, allrunning=1, allhalted=0.
  - allresumeack stays 1 until the next accepted resumereq_w1.
- cmd_req outside HALTED/CMD: cmderr=4 (if 0), cmd_done pulses next cycle, no core access.
- cmderr rules:
  - Sticky; written only when currently 0.
  - Cleared by cmderr_clr.
  - cmderr_clr coincident with a new error: the clear wins and the error is lost.
- cmd_busy and core_reg_access are never high outside CMD. core_haltreq and core_resumereq are never high together.
- Reset mid-command: access dropped immediately, no cmd_done.

Optional Feature:
- Macro: DM_HALT_ON_RESET_EN.
- Defined: reset state is HALTING with core_haltreq=1 and allrunning=0, so the hart halts before executing its first instruction once sys_rstn releases.
- Undefined: reset state is RUNNING as above.

Test Plan:
- haltreq=1, core_halted rises 3 cycles later -> core_haltreq high for exactly those cycles, allhalted=1, allrunning=0.
- Halted; cmd_req read regno=0x1002, core returns 0xDEADBEEF after 4 cycles -> core_reg_access high 4 cycles, cmd_rdata=0xDEADBEEF, one cmd_done pulse, cmderr=0.
- Running; cmd_req -> cmderr=4, no core_reg_access; cmderr_clr -> cmderr=0.
- Halted; write cmd with core never responding, CMD_TIMEOUT=16 -> access drops after 16 cycles, cmderr=3, cmd_done pulse.
- Halted; resumereq_w1, core_halted falls after 2 cycles -> core_resumereq high 2 cycles, allresumeack=1, allrunning=1. Repeat with haltreq=1 -> resume ignored.
- In CMD, second cmd_req -> cmderr=1, first command completes normally. With DM_HALT_ON_RESET_EN defined -> core_haltreq=1 immediately after reset release.
